unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported, 4096x32 synchronous data RAM between two requesters: the instruction-fetch stage and the MEM-stage load/store unit.
- Arbitrates per cycle and issues the RAM command in the same cycle.
- Routes the one-cycle-latency read data back to the winning requester.
- Prevents fetch starvation with a bounded-priority counter and supports squashing in-flight fetches on taken branches.

Parameters:
- ADDR_WIDTH, 12, RAM word-address width (DEPTH = 4096).
- DATA_WIDTH, 32, data width in bits.
- DATA_BYTES, 4, byte-lane count (DATA_WIDTH/8).
- STARVE_LIMIT, 4, max consecutive data grants while fetch is waiting before fetch is forced through (range 1..15).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req_i  in  1  fetch read request.
- if_addr_i  in  32  fetch byte address.
- if_flush_i  in  1  taken branch/jump; squash the in-flight fetch response.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  32  fetch read data.
- d_req_i  in  1  load/store request.
- d_we_i  in  DATA_BYTES  byte write enables; all-zero means load.
- d_addr_i  in  32  data byte address.
- d_wdata_i  in  DATA_WIDTH  store data, already lane-aligned.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  load data valid.
- d_rdata_o  out  DATA_WIDTH  load data.
- mem_en_o  out  1  RAM enable.
- mem_we_o  out  DATA_BYTES  RAM byte write enables.
- mem_addr_o  out  ADDR_WIDTH  RAM word address.
- mem_wdata_o  out  DATA_WIDTH  RAM write data.
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after a read enable.
- conflict_cnt_o  out  32  saturating count of cycles with both requests asserted.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values:
  - all outputs 0;
  - response-owner register = NONE;
  - starve counter = 0;
  - conflict_cnt_o = 0.
- Arbitration is combinational within the cycle. Exactly one or zero grants per cycle; if_gnt_o and d_gnt_o are never both 1.
- Priority:
  - data wins by default;
  - fetch wins when starve_cnt == STARVE_LIMIT and if_req_i is 1;
  - a lone requester always wins.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) on each cycle d_gnt_o=1 while if_req_i=1;
  - clears on if_gnt_o=1 or when if_req_i=0.
- Granted command drives RAM the same cycle:
  - mem_en_o=1;
  - mem_addr_o = addr[ADDR_WIDTH+1:2];
  - mem_we_o = d_we_i for data, 0 for fetch;
  - mem_wdata_o = d_wdata_i for data, 0 for fetch.
- Address handling: upper address bits above ADDR_WIDTH+1 are ignored (wrap-around); bits [1:0] are ignored.
- With no grant: mem_en_o=0, mem_we_o=0.
- Response-owner register {NONE, IF, D} is loaded at the clock edge:
  - IF on a fetch grant;
  - D on a data grant with d_we_i==0;
  - NONE otherwise (stores and idle).
- Response cycle (latency exactly 1):
  - owner IF → if_rvalid_o=1, if_rdata_o=mem_rdata_i;
  - owner D → d_rvalid_o=1, d_rdata_o=mem_rdata_i;
  - rdata outputs are 0 when their rvalid is 0.
  - Stores produce no rvalid.
- Flush:
  - if_flush_i=1 in a fetch-grant cycle → owner loads NONE instead of IF;
  - if_flush_i=1 in the IF response cycle → if_rvalid_o forced 0;
  - flush never affects data traffic or grants.
- Throughput: a new grant is allowed in the same cycle as a response, giving full back-to-back 1 access/cycle.
- Requester protocol:
  - hold req/addr/data stable until gnt;
  - may withdraw req before gnt with no side effects;
  - the arbiter holds no request storage.
- conflict_cnt_o: +1 each cycle if_req_i & d_req_i; saturates at 0xFFFFFFFF.
- Reset mid-operation: a pending response is discarded; no rvalid on the first cycle after rst deasserts.

Test Plan:
- Isolated fetch: if_req_i=1, if_addr_i=0x0000_0010, RAM word 4 = 0xDEADBEEF → cycle0 if_gnt_o=1, mem_addr_o=4, mem_we_o=0; cycle1 if_rvalid_o=1, if_rdata_o=0xDEADBEEF.
- Store then load: d_we_i=4'b0011, d_addr_i=0x20, d_wdata_i=0x0000ABCD → mem_we_o=0011, mem_addr_o=8, no d_rvalid_o. Next cycle load 0x20 → following cycle d_rvalid_o=1 with lanes [15:0]=0xABCD.
- Contention/starvation: if_req_i and d_req_i both held high 8 cycles, STARVE_LIMIT=4 → grant sequence D,D,D,D,IF,D,D,D; conflict_cnt_o=8.
- Flush: fetch granted at cycle0 with if_flush_i=1 → if_rvalid_o=0 at cycle1. Repeat with flush asserted at cycle1 instead → if_rvalid_o=0. Interleaved data load still returns d_rvalid_o=1.
- Reset mid-read: load granted, rst asserted before the next edge → all outputs 0 immediately; after release no d_rvalid_o, starve_cnt=0, conflict_cnt_o=0.
- Address wrap: d_addr_i=0x0000_4004 load → mem_addr_o=1, same data as address 0x4.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported 4096x32 synchronous RAM between fetch and load/store.
// Ports: if_* fetch side, d_* load/store side, mem_* RAM side, conflict_cnt_o stats.
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int DATA_BYTES   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [31:0]           if_addr_i,
    input  logic                  if_flush_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [31:0]           if_rdata_o,
    input  logic                  d_req_i,
    input  logic [DATA_BYTES-1:0] d_we_i,
    input  logic [31:0]           d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  mem_en_o,
    output logic [DATA_BYTES-1:0] mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [31:0]           conflict_cnt_o
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_t     owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic       fetch_prio;
    logic       unused_addr_bits;

    // Address bits outside the word index are ignored (wrap-around).
    assign unused_addr_bits = ^{if_addr_i[31:ADDR_WIDTH+2], if_addr_i[1:0],
                                d_addr_i[31:ADDR_WIDTH+2], d_addr_i[1:0]};

    assign fetch_prio = (starve_q == LIMIT);

    // Grants are masked during reset so every output reads 0 immediately.
    always_comb begin
        if_gnt_o = 1'b0;
        d_gnt_o  = 1'b0;
        if (!rst) begin
            if (if_req_i && (!d_req_i || fetch_prio)) begin
                if_gnt_o = 1'b1;
            end else if (d_req_i) begin
                d_gnt_o = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (d_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i[ADDR_WIDTH+1:2];
            mem_wdata_o = d_wdata_i;
        end else if (if_gnt_o) begin
            mem_en_o   = 1'b1;
            mem_addr_o = if_addr_i[ADDR_WIDTH+1:2];
        end
    end

    // A fetch granted under flush is already stale; don't return it.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt_o && !if_flush_i) begin
            owner_d = OWN_IF;
        end else if (d_gnt_o && (d_we_i == '0)) begin
            owner_d = OWN_D;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (if_gnt_o || !if_req_i) begin
            starve_d = '0;
        end else if (d_gnt_o && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q        <= OWN_NONE;
            starve_q       <= '0;
            conflict_cnt_o <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            if (if_req_i && d_req_i && (conflict_cnt_o != '1)) begin
                conflict_cnt_o <= conflict_cnt_o + 32'd1;
            end
        end
    end

    // A flush in the response cycle kills the returning fetch word.
    assign if_rvalid_o = (owner_q == OWN_IF) && !if_flush_i;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rvalid_o  = (owner_q == OWN_D);
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

endmodule
